// File: rtl/mem_req_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32_mem_pkg
// Brief    : Shared constants, the controller state enum and the request
//            legality check for the RV32I unified memory request controller.
// Revision : 1.0 - initial release
// ============================================================================
package rv32_mem_pkg;

   // RV32I load/store width codes (funct3)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int MEM_LAT_DEFAULT = 1;
   localparam int XLEN_DEFAULT    = 32;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WRITE = 3'd2,
      ST_RESP  = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   // A request is rejected when it is misaligned for its width or carries a
   // funct3 that has no meaning for its direction. Fetches ignore funct3 and
   // the write flag and are always word accesses.
   function automatic logic req_is_err(input logic       fetch,
                                       input logic       write,
                                       input logic [2:0] f3,
                                       input logic [1:0] addr_lo);
      logic err;
      err = 1'b0;
      if (fetch) begin
         err = (addr_lo != 2'b00);
      end else begin
         case (f3)
            F3_B:    err = 1'b0;
            F3_H:    err = addr_lo[0];
            F3_W:    err = (addr_lo != 2'b00);
            F3_BU:   err = write;
            F3_HU:   err = write | addr_lo[0];
            default: err = 1'b1;
         endcase
      end
      return err;
   endfunction

endpackage : rv32_mem_pkg
`default_nettype wire

// File: rtl/mem_req_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_ctrl_if
// Brief    : Request/response handshake plus word-addressed memory bus of the
//            memory request controller. "slave" is the controller's view,
//            "master" is the view of the control path together with memory.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_req_ctrl_if;
   import rv32_mem_pkg::*;

   // request side
   logic                    req_valid;
   logic                    req_ready;
   logic                    req_fetch;
   logic                    req_write;
   logic [2:0]              req_funct3;
   logic [XLEN_DEFAULT-1:0] req_addr;
   logic [XLEN_DEFAULT-1:0] req_wdata;
   // response side
   logic                    resp_valid;
   logic                    resp_err;
   logic [XLEN_DEFAULT-1:0] resp_rdata;
   logic [XLEN_DEFAULT-1:0] instruction_reg;
   // memory side
   logic [XLEN_DEFAULT-1:0] mem_addr;
   logic                    mem_we;
   logic [XLEN_DEFAULT-1:0] mem_wdata;
   logic [XLEN_DEFAULT-1:0] mem_rdata;

   modport slave (
      input  req_valid, req_fetch, req_write, req_funct3, req_addr, req_wdata,
      input  mem_rdata,
      output req_ready, resp_valid, resp_err, resp_rdata, instruction_reg,
      output mem_addr, mem_we, mem_wdata
   );

   modport master (
      output req_valid, req_fetch, req_write, req_funct3, req_addr, req_wdata,
      output mem_rdata,
      input  req_ready, resp_valid, resp_err, resp_rdata, instruction_reg,
      input  mem_addr, mem_we, mem_wdata
   );

endinterface : mem_req_ctrl_if
`default_nettype wire

// File: rtl/mem_req_ctrl_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_align
// Brief    : Combinational byte-lane logic. Extracts and sign/zero-extends load
//            data from a memory word, and merges right-aligned store data into
//            a memory word for sub-word stores. Little-endian lanes.
// Revision : 1.0 - initial release
// ============================================================================
module mem_align
   import rv32_mem_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] store_o
);

   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   // Pick the addressed lane, then extend it for loads or replace it for stores
   always_comb begin
      case (addr_lo_i)
         2'b00:   sel_byte = word_i[7:0];
         2'b01:   sel_byte = word_i[15:8];
         2'b10:   sel_byte = word_i[23:16];
         default: sel_byte = word_i[31:24];
      endcase
      sel_half = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

      case (funct3_i)
         F3_B:    load_o = {{24{sel_byte[7]}}, sel_byte};
         F3_BU:   load_o = {24'h0, sel_byte};
         F3_H:    load_o = {{16{sel_half[15]}}, sel_half};
         F3_HU:   load_o = {16'h0, sel_half};
         default: load_o = word_i;
      endcase

      store_o = word_i;
      case (funct3_i)
         F3_B: begin
            case (addr_lo_i)
               2'b00:   store_o[7:0]   = wdata_i[7:0];
               2'b01:   store_o[15:8]  = wdata_i[7:0];
               2'b10:   store_o[23:16] = wdata_i[7:0];
               default: store_o[31:24] = wdata_i[7:0];
            endcase
         end
         F3_H: begin
            if (addr_lo_i[1]) store_o[31:16] = wdata_i[15:0];
            else              store_o[15:0]  = wdata_i[15:0];
         end
         F3_W:    store_o = wdata_i;
         default: store_o = word_i;
      endcase
   end

endmodule : mem_align
`default_nettype wire

// File: rtl/mem_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_ctrl
// Brief    : Initiator side of the unified instruction/data memory port of a
//            multicycle RV32I core. One fetch/load/store at a time, sub-word
//            stores via read-modify-write, registered outputs throughout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_ctrl
   import rv32_mem_pkg::*;
#(
   parameter int MEM_LAT = MEM_LAT_DEFAULT,
   parameter int XLEN    = XLEN_DEFAULT
) (
   input  logic          clk,
   input  logic          reset,
   mem_req_ctrl_if.slave bus
);

   // Read data is taken when the wait counter reaches this value
   localparam logic [2:0] LAT_CNT = 3'(MEM_LAT);

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;

   // request captured in the acceptance cycle
   logic              fetch_q, fetch_d;
   logic              write_q, write_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        addr_lo_q, addr_lo_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;

   // registered outputs
   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;
   logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
   logic [XLEN-1:0]   instr_q, instr_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
   logic              mem_we_q, mem_we_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;

   logic [2:0]        align_f3;
   logic [31:0]       align_load;
   logic [31:0]       align_store;

   // Fetches are plain word reads regardless of the funct3 they arrived with
   assign align_f3 = fetch_q ? F3_W : funct3_q;

   mem_align u_align (
      .funct3_i  (align_f3),
      .addr_lo_i (addr_lo_q),
      .word_i    (bus.mem_rdata),
      .wdata_i   (wdata_q),
      .load_o    (align_load),
      .store_o   (align_store)
   );

   // Next-state and next-output logic; pulses default low, everything else holds
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      fetch_d      = fetch_q;
      write_d      = write_q;
      funct3_d     = funct3_q;
      addr_lo_d    = addr_lo_q;
      wdata_d      = wdata_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = resp_rdata_q;
      instr_d      = instr_q;
      mem_addr_d   = mem_addr_q;
      mem_we_d     = 1'b0;
      mem_wdata_d  = mem_wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               fetch_d   = bus.req_fetch;
               write_d   = bus.req_write & ~bus.req_fetch;
               funct3_d  = bus.req_funct3;
               addr_lo_d = bus.req_addr[1:0];
               wdata_d   = bus.req_wdata;
               cnt_d     = 3'd0;
               if (req_is_err(bus.req_fetch, bus.req_write, bus.req_funct3,
                              bus.req_addr[1:0])) begin
                  // rejected requests never drive the memory bus
                  state_d      = ST_ERR;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  mem_addr_d = {bus.req_addr[XLEN-1:2], 2'b00};
                  if (!bus.req_fetch && bus.req_write && (bus.req_funct3 == F3_W)) begin
                     // full-word store needs no read, write straight away
                     state_d     = ST_WRITE;
                     mem_we_d    = 1'b1;
                     mem_wdata_d = bus.req_wdata;
                  end else begin
                     state_d = ST_READ;
                  end
               end
            end
         end

         ST_READ: begin
            if (cnt_q == LAT_CNT) begin
               if (write_q) begin
                  // sub-word store: merge into the word just read
                  state_d     = ST_WRITE;
                  mem_we_d    = 1'b1;
                  mem_wdata_d = align_store;
               end else begin
                  state_d      = ST_RESP;
                  resp_valid_d = 1'b1;
                  resp_rdata_d = align_load;
                  if (fetch_q) instr_d = bus.mem_rdata;
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end

         ST_WRITE: begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
         end

         ST_RESP,
         ST_ERR: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      req_ready_d = (state_d == ST_IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 3'd0;
         fetch_q      <= 1'b0;
         write_q      <= 1'b0;
         funct3_q     <= 3'd0;
         addr_lo_q    <= 2'd0;
         wdata_q      <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         instr_q      <= '0;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         fetch_q      <= fetch_d;
         write_q      <= write_d;
         funct3_q     <= funct3_d;
         addr_lo_q    <= addr_lo_d;
         wdata_q      <= wdata_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         instr_q      <= instr_d;
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign bus.req_ready       = req_ready_q;
   assign bus.resp_valid      = resp_valid_q;
   assign bus.resp_err        = resp_err_q;
   assign bus.resp_rdata      = resp_rdata_q;
   assign bus.instruction_reg = instr_q;
   assign bus.mem_addr        = mem_addr_q;
   assign bus.mem_we          = mem_we_q;
   assign bus.mem_wdata       = mem_wdata_q;

endmodule : mem_req_ctrl
`default_nettype wire

// File: tb/tb_mem_req_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_req_ctrl
// Brief    : Self-checking bench for mem_req_ctrl with MEM_LAT = 1: vector
//            table of requests, scoreboard queues for responses and writes,
//            plus reset-abort and back-to-back sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_ctrl;
   import rv32_mem_pkg::*;

   localparam int LAT = 1;

   typedef struct {
      string       name;
      logic        fetch;
      logic        write;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] init;   // memory word preloaded before the request
      logic        err;
      logic [31:0] rdata;  // expected load/fetch result
      int          lat;    // cycle of resp_valid relative to acceptance
      int          we_off; // cycle of mem_we relative to acceptance, 0 = none
      logic [31:0] wword;
   } vec_t;

   typedef struct {
      string       name;
      logic        err;
      logic [31:0] rdata;
      logic [31:0] instr;
      logic [31:0] maddr;
      int          cyc;
   } exp_t;

   typedef struct {
      string       name;
      int          cyc;
      logic [31:0] addr;
      logic [31:0] data;
   } wexp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_req_ctrl_if bus ();

   mem_req_ctrl #(.MEM_LAT(LAT), .XLEN(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // memory model: one registered read stage gives exactly MEM_LAT = 1
   logic [31:0] mem [0:255];
   logic [31:0] rd_q;
   logic        pre_en = 1'b0;
   logic [7:0]  pre_idx = 8'd0;
   logic [31:0] pre_val = 32'd0;

   always @(posedge clk) begin
      if (pre_en)          mem[pre_idx] <= pre_val;
      else if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      rd_q <= mem[bus.mem_addr[9:2]];
   end
   assign bus.mem_rdata = rd_q;

   int          n_checks = 0;
   int          n_errors = 0;
   exp_t        sb[$];
   wexp_t       wq[$];
   vec_t        vecs[$];
   logic [31:0] model_rdata = 32'd0;
   logic [31:0] model_instr = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(input string name, input logic fetch, input logic write,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] init,
                               input logic err, input logic [31:0] rdata, input int lat,
                               input int we_off, input logic [31:0] wword);
      vec_t v;
      v.name = name;   v.fetch = fetch; v.write = write; v.f3 = f3;
      v.addr = addr;   v.wdata = wdata; v.init = init;   v.err = err;
      v.rdata = rdata; v.lat = lat;     v.we_off = we_off; v.wword = wword;
      return v;
   endfunction

   // Pops the scoreboards whenever the DUT responds or writes
   task automatic monitor();
      exp_t  e;
      wexp_t w;
      forever begin
         @(negedge clk);
         if (bus.resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL unexpected_resp: resp_valid=1 with nothing outstanding, expected 0 (cycle %0d)", cyc);
            end else begin
               e = sb.pop_front();
               chk({e.name, "_cyc"},   32'(cyc), 32'(e.cyc));
               chk({e.name, "_err"},   {31'd0, bus.resp_err}, {31'd0, e.err});
               chk({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
               chk({e.name, "_instr"}, bus.instruction_reg, e.instr);
               if (!e.err) chk({e.name, "_maddr"}, bus.mem_addr, e.maddr);
            end
         end
         if (bus.mem_we === 1'b1) begin
            if (wq.size() == 0) begin
               n_checks++; n_errors++;
               $display("FAIL unexpected_we: mem_we=1 addr %h data %h, expected no write (cycle %0d)",
                        bus.mem_addr, bus.mem_wdata, cyc);
            end else begin
               w = wq.pop_front();
               chk({w.name, "_we_cyc"}, 32'(cyc), 32'(w.cyc));
               chk({w.name, "_we_addr"}, bus.mem_addr, w.addr);
               chk({w.name, "_we_data"}, bus.mem_wdata, w.data);
            end
         end
      end
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] val);
      pre_idx = idx;
      pre_val = val;
      pre_en  = 1'b1;
      @(posedge clk); #1;
      pre_en  = 1'b0;
   endtask

   // Drives one request and records what it must produce, c0 = acceptance cycle
   task automatic issue(input vec_t v, input int c0);
      exp_t  e;
      wexp_t w;
      bus.req_valid  = 1'b1;
      bus.req_fetch  = v.fetch;
      bus.req_write  = v.write;
      bus.req_funct3 = v.f3;
      bus.req_addr   = v.addr;
      bus.req_wdata  = v.wdata;
      e.name  = v.name;
      e.err   = v.err;
      e.rdata = (!v.err && (v.fetch || !v.write)) ? v.rdata : model_rdata;
      e.instr = (!v.err && v.fetch) ? v.rdata : model_instr;
      e.maddr = {v.addr[31:2], 2'b00};
      e.cyc   = c0 + v.lat;
      model_rdata = e.rdata;
      model_instr = e.instr;
      sb.push_back(e);
      if (v.we_off != 0) begin
         w.name = v.name;
         w.cyc  = c0 + v.we_off;
         w.addr = e.maddr;
         w.data = v.wword;
         wq.push_back(w);
      end
   endtask

   // Scramble request fields once acceptance is over; the DUT must ignore them
   task automatic release_req();
      bus.req_valid  = 1'b0;
      bus.req_fetch  = 1'($urandom_range(0, 1));
      bus.req_write  = 1'($urandom_range(0, 1));
      bus.req_funct3 = 3'($urandom_range(0, 7));
      bus.req_addr   = $urandom();
      bus.req_wdata  = $urandom();
   endtask

   task automatic wait_ready(input string name);
      int budget = 0;
      while (bus.req_ready !== 1'b1 && budget < 20) begin
         @(negedge clk); #2;
         budget++;
      end
      chk({name, "_ready_hi"}, {31'd0, bus.req_ready}, 32'd1);
   endtask

   task automatic wait_drain(input string name);
      int budget = 0;
      while (sb.size() != 0 && budget < 20) begin
         @(negedge clk); #2;
         budget++;
      end
      chk({name, "_resp_pending"}, 32'(sb.size()), 32'd0);
      chk({name, "_we_pending"},   32'(wq.size()), 32'd0);
      sb.delete();
      wq.delete();
   endtask

   task automatic run_vec(input vec_t v);
      preload(v.addr[9:2], v.init);
      wait_ready(v.name);
      issue(v, cyc);
      @(posedge clk); #1;
      release_req();
      chk({v.name, "_ready_lo"}, {31'd0, bus.req_ready}, 32'd0);
      wait_drain(v.name);
   endtask

   task automatic check_idle(input string name);
      chk({name, "_req_ready"},  {31'd0, bus.req_ready}, 32'd1);
      chk({name, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
      chk({name, "_resp_err"},   {31'd0, bus.resp_err}, 32'd0);
      chk({name, "_resp_rdata"}, bus.resp_rdata, 32'd0);
      chk({name, "_instr"},      bus.instruction_reg, 32'd0);
      chk({name, "_mem_addr"},   bus.mem_addr, 32'd0);
      chk({name, "_mem_we"},     {31'd0, bus.mem_we}, 32'd0);
      chk({name, "_mem_wdata"},  bus.mem_wdata, 32'd0);
   endtask

   initial begin
      vec_t v1;
      vec_t v2;

      bus.req_valid  = 1'b0;
      bus.req_fetch  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;

      //          name             fe wr f3      addr    wdata         init          er rdata         lat we wword
      vecs.push_back(mk("fetch_008",     1, 0, 3'b000, 32'h008, 32'h0,        32'h45628748, 0, 32'h45628748, 3, 0, 32'h0));
      vecs.push_back(mk("lb_203",        0, 0, F3_B,   32'h203, 32'h0,        32'haabbccdd, 0, 32'hffffffaa, 3, 0, 32'h0));
      vecs.push_back(mk("lbu_203",       0, 0, F3_BU,  32'h203, 32'h0,        32'haabbccdd, 0, 32'h000000aa, 3, 0, 32'h0));
      vecs.push_back(mk("lh_202",        0, 0, F3_H,   32'h202, 32'h0,        32'haabbccdd, 0, 32'hffffaabb, 3, 0, 32'h0));
      vecs.push_back(mk("lhu_200",       0, 0, F3_HU,  32'h200, 32'h0,        32'haabbccdd, 0, 32'h0000ccdd, 3, 0, 32'h0));
      vecs.push_back(mk("lw_200",        0, 0, F3_W,   32'h200, 32'h0,        32'haabbccdd, 0, 32'haabbccdd, 3, 0, 32'h0));
      vecs.push_back(mk("lb_200_pos",    0, 0, F3_B,   32'h200, 32'h0,        32'h12345678, 0, 32'h00000078, 3, 0, 32'h0));
      vecs.push_back(mk("lh_200_neg",    0, 0, F3_H,   32'h200, 32'h0,        32'h00008001, 0, 32'hffff8001, 3, 0, 32'h0));
      vecs.push_back(mk("lhu_202",       0, 0, F3_HU,  32'h202, 32'h0,        32'h80001234, 0, 32'h00008000, 3, 0, 32'h0));
      vecs.push_back(mk("sw_200",        0, 1, F3_W,   32'h200, 32'h11223344, 32'haabbccdd, 0, 32'h0,        2, 1, 32'h11223344));
      vecs.push_back(mk("sb_201",        0, 1, F3_B,   32'h201, 32'h000000ee, 32'haabbccdd, 0, 32'h0,        4, 3, 32'haabbeedd));
      vecs.push_back(mk("sh_202",        0, 1, F3_H,   32'h202, 32'h00001234, 32'haabbccdd, 0, 32'h0,        4, 3, 32'h1234ccdd));
      vecs.push_back(mk("sb_200_upper",  0, 1, F3_B,   32'h200, 32'hffffff99, 32'haabbccdd, 0, 32'h0,        4, 3, 32'haabbcc99));
      vecs.push_back(mk("sh_200_upper",  0, 1, F3_H,   32'h200, 32'hdead5678, 32'haabbccdd, 0, 32'h0,        4, 3, 32'haabb5678));
      vecs.push_back(mk("sh_201_err",    0, 1, F3_H,   32'h201, 32'h00001234, 32'haabbccdd, 1, 32'h0,        1, 0, 32'h0));
      vecs.push_back(mk("ld_f3_011_err", 0, 0, 3'b011, 32'h200, 32'h0,        32'haabbccdd, 1, 32'h0,        1, 0, 32'h0));
      vecs.push_back(mk("fetch_006_err", 1, 0, F3_W,   32'h006, 32'h0,        32'h0,        1, 32'h0,        1, 0, 32'h0));
      vecs.push_back(mk("sbu_err",       0, 1, F3_BU,  32'h200, 32'h0,        32'haabbccdd, 1, 32'h0,        1, 0, 32'h0));
      vecs.push_back(mk("lw_202_err",    0, 0, F3_W,   32'h202, 32'h0,        32'haabbccdd, 1, 32'h0,        1, 0, 32'h0));
      vecs.push_back(mk("ld_f3_110_err", 0, 0, 3'b110, 32'h200, 32'h0,        32'haabbccdd, 1, 32'h0,        1, 0, 32'h0));
      vecs.push_back(mk("fetch_ign_f3",  1, 1, 3'b111, 32'h00c, 32'h0,        32'h00500093, 0, 32'h00500093, 3, 0, 32'h0));

      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check_idle("reset");

      for (int i = 0; i < vecs.size(); i++) begin
         run_vec(vecs[i]);
      end

      // reset in cycle 1 of a sub-word store aborts it with no write or response
      preload(8'h80, 32'haabbccdd);
      wait_ready("rst_sb");
      bus.req_valid  = 1'b1;
      bus.req_fetch  = 1'b0;
      bus.req_write  = 1'b1;
      bus.req_funct3 = F3_B;
      bus.req_addr   = 32'h201;
      bus.req_wdata  = 32'hee;
      @(posedge clk); #1;
      release_req();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_rdata = 32'd0;
      model_instr = 32'd0;
      check_idle("rst_abort");
      repeat (6) @(negedge clk);
      chk("rst_abort_mem", mem[8'h80], 32'haabbccdd);

      // back-to-back: second LW raised during the response, accepted the next cycle
      preload(8'h80, 32'h0badf00d);
      preload(8'h02, 32'h45628748);
      v1 = mk("b2b_lw_1", 0, 0, F3_W, 32'h200, 32'h0, 32'h0, 0, 32'h0badf00d, 3, 0, 32'h0);
      v2 = mk("b2b_lw_2", 0, 0, F3_W, 32'h008, 32'h0, 32'h0, 0, 32'h45628748, 3, 0, 32'h0);
      wait_ready("b2b");
      issue(v1, cyc);
      @(posedge clk); #1;
      release_req();
      begin
         int budget = 0;
         while (sb.size() != 0 && budget < 20) begin
            @(negedge clk); #2;
            budget++;
         end
         chk("b2b_first_resp", 32'(sb.size()), 32'd0);
      end
      chk("b2b_ready_in_resp", {31'd0, bus.req_ready}, 32'd0);
      issue(v2, cyc + 1);
      @(posedge clk); #1;
      chk("b2b_ready_accept", {31'd0, bus.req_ready}, 32'd1);
      @(posedge clk); #1;
      release_req();
      chk("b2b_ready_busy", {31'd0, bus.req_ready}, 32'd0);
      wait_drain("b2b");

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_mem_req_ctrl
`default_nettype wire
